// File: rtl/seqdetect_1101_moore_if.sv
// Serial data-path bundle for the 1101 sequence detector.
//   in        : serial data bit toward the detector (master drives)
//   dout      : detect flag from the detector (slave drives)
//   match_cnt : saturating detection count, present only when
//               SEQDET_MATCH_CNT_EN is defined (slave drives)
// Parameter CNT_W sets the width of match_cnt.
interface seqdetect_1101_moore_if #(
  parameter int CNT_W = 8
);
  logic in;
  logic dout;
`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;

  modport master (output in, input dout, input match_cnt);
  modport slave (input in, output dout, output match_cnt);
`else
  modport master (output in, input dout);
  modport slave (input in, output dout);
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
endinterface

// File: rtl/seqdetect_1101_moore.sv
// Moore FSM that detects the serial pattern 1-1-0-1 with overlap.
// One bit is sampled per rising clk edge; dout is high for exactly one
// cycle while the FSM sits in the "pattern complete" state.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   ser : seqdetect_1101_moore_if.slave (in, dout, optional match_cnt)
// Optional feature macro: SEQDET_MATCH_CNT_EN adds a CNT_W-bit
// saturating detection counter driven on ser.match_cnt.
module seqdetect_1101_moore #(
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  seqdetect_1101_moore_if.slave ser
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4   // "1101" complete
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk) begin
    if (rst) state <= S0;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S0;
    case (state)
      S0: next_state = ser.in ? S1 : S0;
      S1: next_state = ser.in ? S2 : S0;
      S2: next_state = ser.in ? S2 : S3;
      S3: next_state = ser.in ? S4 : S0;
      // Trailing 1 of a match plus a new 1 already forms "11".
      S4: next_state = ser.in ? S2 : S0;
      default: next_state = S0;  // unused encodings fall back to idle
    endcase
  end

  assign ser.dout = (state == S4);

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;

  // Counts on the edge that enters S4 so it updates alongside dout.
  always_ff @(posedge clk) begin
    if (rst) match_cnt <= '0;
    else if (next_state == S4 && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
  end

  assign ser.match_cnt = match_cnt;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

endmodule

// File: tb/tb_seqdetect_1101_moore.sv
module tb_seqdetect_1101_moore;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seqdetect_1101_moore_if #(.CNT_W(CNT_W)) sif ();

  seqdetect_1101_moore #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .ser (sif.slave)
  );

  typedef struct {
    bit rst;
    bit din;
    bit exp;
  } vec_t;

  vec_t tbl[$];

  int errors = 0;
  int checks = 0;

  // Reference model: the last four sampled bits since reset, plus a
  // saturating count of how often they spelled 1101.
  bit [3:0]    hist;
  int unsigned mcount;
  bit          m_dout;
  bit          prev_dout;

  function automatic void model_step(input bit r, input bit b);
    if (r) begin
      hist   = 4'b0000;
      mcount = 0;
      m_dout = 1'b0;
    end else begin
      hist   = {hist[2:0], b};
      m_dout = (hist == 4'b1101);
      if (m_dout && mcount < (2**CNT_W) - 1) mcount++;
    end
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name, input int unsigned exp);
`ifdef SEQDET_MATCH_CNT_EN
    checks++;
    if (sif.match_cnt !== exp[CNT_W-1:0]) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, sif.match_cnt, exp, $time);
    end
`else
    if (name.len() == 0 && exp == 0) begin end
`endif
  endtask

  // Apply one bit (or reset) across a rising edge and sample 1 ns later.
  task automatic step(input bit r, input bit b);
    rst    = r;
    sif.in = b;
    @(posedge clk);
    #1;
    model_step(r, b);
  endtask

  // Push n rows, MSB first, from packed bit strings.
  task automatic add(input bit r, input logic [15:0] bits, input logic [15:0] exps, input int n);
    vec_t v;
    for (int i = n - 1; i >= 0; i--) begin
      v.rst = r;
      v.din = bits[i];
      v.exp = exps[i];
      tbl.push_back(v);
    end
  endtask

  initial begin
    hist      = 4'b0000;
    mcount    = 0;
    m_dout    = 1'b0;
    prev_dout = 1'b0;
    sif.in    = 1'b0;

    // Reset hold: two edges with in=0, then in=1 still under reset.
    add(1'b1, 16'b00,            16'b00,            2);
    add(1'b1, 16'b1,             16'b0,             1);
    // Basic match then a trailing 0.
    add(1'b0, 16'b011010,        16'b000010,        6);
    // Overlap: pulses on 4th and 7th bits.
    add(1'b0, 16'b1101101,       16'b0001001,       7);
    // Non-match tail and a run of 1s.
    add(1'b1, 16'b0,             16'b0,             1);
    add(1'b0, 16'b1101011011111, 16'b0001000010000, 13);
    // Run of 1s then 0,1.
    add(1'b1, 16'b0,             16'b0,             1);
    add(1'b0, 16'b111101,        16'b000001,        6);
    // Mid-pattern reset.
    add(1'b1, 16'b0,             16'b0,             1);
    add(1'b0, 16'b110,           16'b000,           3);
    add(1'b1, 16'b1,             16'b0,             1);
    add(1'b0, 16'b1,             16'b0,             1);
    add(1'b0, 16'b1101,          16'b0001,          4);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].din);
      check_bit($sformatf("tbl[%0d].dout", i), sif.dout, tbl[i].exp);
      check_cnt($sformatf("tbl[%0d].cnt", i), mcount);
    end
    check_cnt("mid_reset_cnt", 1);

    // Reset while sitting in S4 drops the pulse and the progress.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_bit("pre_s4_reset", sif.dout, 1'b1);
    step(1'b1, 1'b1);
    check_bit("s4_reset", sif.dout, 1'b0);
    check_cnt("s4_reset_cnt", 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_bit("post_s4_reset_no_pulse", sif.dout, 1'b0);

    // Randomized stream with occasional resets against the model.
    step(1'b1, 1'b0);
    prev_dout = 1'b0;
    for (int i = 0; i < 600; i++) begin
      automatic bit r = ($urandom_range(0, 59) == 0);
      automatic bit b = ($urandom_range(0, 2) != 0);
      step(r, b);
      check_bit("rand_dout", sif.dout, m_dout);
      check_cnt("rand_cnt", mcount);
      if (prev_dout && sif.dout === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL rand_double_pulse: got 1 expected 0 at %0t", $time);
      end
      prev_dout = sif.dout;
    end

`ifdef SEQDET_MATCH_CNT_EN
    // Drive 300 overlapping matches to reach and hold saturation.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check_bit("sat_dout", sif.dout, 1'b1);
      check_cnt("sat_cnt", mcount);
    end
    check_cnt("sat_final", (2**CNT_W) - 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
